// File: rtl/pb_counter_bank_if.sv
// Button/counter bundle between the push-button counter bank and its user.
// The slave side is the counter bank; the master side drives buttons and reads counts.
interface pb_counter_bank_if #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 4
);
   logic [CHANNELS-1:0]       pb;
   logic [CHANNELS-1:0]       dir;
   logic                      clr;
   logic [CHANNELS*CNT_W-1:0] count;
   logic [CHANNELS-1:0]       press;
   logic [CHANNELS-1:0]       carry;

   modport master (
      output pb,
      output dir,
      output clr,
      input  count,
      input  press,
      input  carry
   );

   modport slave (
      input  pb,
      input  dir,
      input  clr,
      output count,
      output press,
      output carry
   );
endinterface

// File: rtl/pb_counter_bank.sv
// Multi-channel push-button counter: per channel a 2-flop synchroniser, debouncer,
// rising-edge press detector and mod-(MAX_COUNT+1) up/down counter (wrap or saturate).
module pb_counter_bank #(
   parameter int CHANNELS   = 2,
   parameter int CNT_W      = 4,
   parameter int MAX_COUNT  = 9,
   parameter int DEB_CYCLES = 16,
   parameter int WRAP       = 1
) (
   input logic              clk,
   input logic              rst_n,
   pb_counter_bank_if.slave bus
);
   localparam int               DEB_W    = $clog2(DEB_CYCLES) + 1;
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_COUNT);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [CHANNELS-1:0] s1_q, s1_d;
   logic [CHANNELS-1:0] s2_q, s2_d;
   logic [CHANNELS-1:0] db_q, db_d;
   logic [CHANNELS-1:0] db_dly_q, db_dly_d;
   logic [CHANNELS-1:0] press_q, press_d;
   logic [CHANNELS-1:0] carry_q, carry_d;
   logic [DEB_W-1:0]    deb_cnt_q [CHANNELS];
   logic [DEB_W-1:0]    deb_cnt_d [CHANNELS];
   logic [CNT_W-1:0]    cnt_q     [CHANNELS];
   logic [CNT_W-1:0]    cnt_d     [CHANNELS];

   logic [CHANNELS-1:0]       rise;
   logic [CNT_W:0]            step;
   logic [DEB_W:0]            deb_next;
   logic [CHANNELS*CNT_W-1:0] count_flat;

   // Returns {accepted level, next debounce count}. A new level is taken only
   // after DEB_CYCLES consecutive samples disagree with the current one.
   function automatic logic [DEB_W:0] debounce(input logic sample, input logic level,
                                               input logic [DEB_W-1:0] cnt);
      logic [DEB_W:0] res;
      if (sample == level)
         res = {level, {DEB_W{1'b0}}};
      else if (cnt == DEB_LAST)
         res = {sample, {DEB_W{1'b0}}};
      else
         res = {level, cnt + 1'b1};
      return res;
   endfunction

   // Returns {carry, next count} for one accepted press in the given direction.
   function automatic logic [CNT_W:0] step_count(input logic [CNT_W-1:0] cur,
                                                 input logic down);
      logic [CNT_W:0] res;
      if (!down) begin
         if (cur < MAX_C)
            res = {1'b0, cur + 1'b1};
         else
            res = {1'b1, (WRAP != 0) ? {CNT_W{1'b0}} : MAX_C};
      end else begin
         if (cur != {CNT_W{1'b0}})
            res = {1'b0, cur - 1'b1};
         else
            res = {1'b1, (WRAP != 0) ? MAX_C : {CNT_W{1'b0}}};
      end
      return res;
   endfunction

   always_comb begin
      s1_d     = bus.pb;
      s2_d     = s1_q;
      db_d     = db_q;
      db_dly_d = db_q;
      press_d  = '0;
      carry_d  = '0;
      rise     = '0;
      step     = '0;
      deb_next = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         cnt_d[i]     = cnt_q[i];
      end

      for (int i = 0; i < CHANNELS; i++) begin
         deb_next     = debounce(s2_q[i], db_q[i], deb_cnt_q[i]);
         db_d[i]      = deb_next[DEB_W];
         deb_cnt_d[i] = deb_next[DEB_W-1:0];

         rise[i]    = db_q[i] & ~db_dly_q[i];
         press_d[i] = rise[i];

         // Clear wins over a simultaneous press; the press pulse is still reported.
         step = step_count(cnt_q[i], bus.dir[i]);
         if (bus.clr) begin
            cnt_d[i] = '0;
         end else if (rise[i]) begin
            cnt_d[i]   = step[CNT_W-1:0];
            carry_d[i] = step[CNT_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= '0;
         s2_q     <= '0;
         db_q     <= '0;
         db_dly_q <= '0;
         press_q  <= '0;
         carry_q  <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            deb_cnt_q[i] <= '0;
            cnt_q[i]     <= '0;
         end
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         db_q     <= db_d;
         db_dly_q <= db_dly_d;
         press_q  <= press_d;
         carry_q  <= carry_d;
         for (int i = 0; i < CHANNELS; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
            cnt_q[i]     <= cnt_d[i];
         end
      end
   end

   always_comb begin
      count_flat = '0;
      for (int i = 0; i < CHANNELS; i++)
         count_flat[i*CNT_W +: CNT_W] = cnt_q[i];
   end

   assign bus.count = count_flat;
   assign bus.press = press_q;
   assign bus.carry = carry_q;
endmodule
